xadc_frame_capture: RTL and testbench
=====================================

# xadc_frame_capture

- Parametrised XADC sequence capture engine; successor to the fixed two-channel control register.
- Snoops the XADC wizard's sequencer outputs and issues one DRP read per end-of-conversion.
- Assembles results for `NUM_CH` contiguous auxiliary channels into one frame per end-of-sequence.
- Presents frames on a valid/ready stream toward the sample buffer. It optionally box-car averages several sequences per frame and counts frames lost to back-pressure.

## Interface

Parameters:
- `NUM_CH`, 2: number of captured channels, 1..16.
- `BASE_CH`, 5'h14: XADC channel number of slot 0. Slot i is channel `BASE_CH+i`.
- `CODE_W`, 12: ADC code width. Taken from `drp_do[15 -: CODE_W]`.
- `AVG_LOG2`, 2: log2 of sequences averaged per frame. Used only with averaging compiled in.
- `RDY_TIMEOUT`, 63: maximum cycles to wait for `drp_drdy`.

Ports:
- `clk`, in, 1: system clock; also the XADC DCLK.
- `reset`, in, 1: synchronous, active-high.
- `eoc_in`, in, 1: XADC end-of-conversion pulse.
- `eos_in`, in, 1: XADC end-of-sequence pulse.
- `channel_in`, in, 5: XADC `channel_out`.
- `drp_den`, out, 1: DRP enable, one-cycle pulse.
- `drp_dwe`, out, 1: DRP write enable. Constant 0; the block only reads.
- `drp_daddr`, out, 7: DRP address.
- `drp_do`, in, 16: DRP read data.
- `drp_drdy`, in, 1: DRP data ready.
- `frame_valid`, out, 1: frame available.
- `frame_ready`, in, 1: consumer accepts the frame.
- `frame_data`, out, NUM_CH*CODE_W: slot i is at bits `[i*CODE_W +: CODE_W]`.
- `frame_seq`, out, 8: sequence number of the presented frame; wraps.
- `overflow_cnt`, out, 16: frames dropped while the output was full. Saturates at 16'hFFFF.
- `timeout_cnt`, out, 8: DRP reads abandoned on timeout. Saturates at 8'hFF.

## Operation

Read FSM:
- IDLE:
  - On `eoc_in` with `BASE_CH <= channel_in < BASE_CH+NUM_CH`: register `drp_daddr={2'b0,channel_in}`, latch slot = `channel_in-BASE_CH`, pulse `drp_den`, go to WAIT.
  - Out-of-range channels are ignored.
- WAIT:
  - On `drp_drdy`: write `drp_do[15 -: CODE_W]` into the slot's shadow register, set `slot_ok[slot]`, go to IDLE.
  - If `RDY_TIMEOUT` cycles pass without `drp_drdy`: increment `timeout_cnt` and go to IDLE. The slot stays invalid.
  - `eoc_in` in WAIT is ignored.
- `eos_in` sets `eos_pend` in any state.

Commit (FSM in IDLE, `eos_pend` set, no `eoc_in` starting a read that cycle):
- Clear `eos_pend`, increment the sequence counter (mod 256), and clear `slot_ok`.
- If every `slot_ok` bit was set, the sequence is complete; otherwise it is discarded without a frame.

Frame production:
- A complete sequence produces a frame (without averaging), or contributes to one (with averaging).
- The frame loads the output register if `!frame_valid`, or if `frame_valid && frame_ready` in the same cycle.
- Otherwise the frame is dropped, `overflow_cnt` increments, and the presented frame is held unchanged.

Output stream:
- `frame_valid` stays high until a cycle with `frame_ready=1`.
- `frame_data` and `frame_seq` are stable while `frame_valid && !frame_ready`.

## Timing

- Reset values:
  - `drp_den=0`, `drp_dwe=0`, `drp_daddr=0`
  - `frame_valid=0`, `frame_data=0`, `frame_seq=0`
  - `overflow_cnt=0`, `timeout_cnt=0`
  - FSM in IDLE; `slot_ok`, `eos_pend` and accumulators cleared.
  - Reset mid-read abandons the read with no counter change.
- `drp_den` and `drp_daddr` are valid in the cycle after `eoc_in`.
- The shadow register updates in the cycle after `drp_drdy`.
- Commit happens no earlier than the cycle after the last `drp_drdy` of the sequence.
- `frame_valid` rises in the cycle after commit.
- Simultaneous `eos_in` and `drp_drdy`: the read completes first, then commit follows the next cycle. This is the normal XADC ordering (eos accompanies the final eoc).
- `eos_in` with zero reads in the sequence: `slot_ok` is all zero, so the sequence is discarded.

## Configuration

`XADC_FRAME_AVG_EN`:
- Defined:
  - Each slot has an accumulator of width `CODE_W+AVG_LOG2`.
  - Every complete sequence adds its codes to the accumulators.
  - After `2**AVG_LOG2` complete sequences, the frame is each accumulator `>> AVG_LOG2` (truncating), and the accumulators clear.
  - Discarded sequences neither add nor count.
  - `frame_seq` is the number of the last contributing sequence.
- Undefined: every complete sequence is a frame, and no accumulators are built.

## Test plan

- Basic frame, NUM_CH=2, BASE_CH=5'h14, macro off:
  - Stimulus: eoc ch 0x14 with do=16'hABC0, eoc ch 0x15 with do=16'h1230, then eos, `frame_ready=1`.
  - Required: one frame, `frame_data={12'h123,12'hABC}`, `frame_seq=1`.
- Out-of-range and incomplete:
  - Stimulus: eoc ch 0x10 (no `drp_den` issued), read only ch 0x14, then eos.
  - Required: no frame, `frame_seq` of the next frame is 2.
- Back-pressure:
  - Stimulus: `frame_ready=0`, three complete sequences.
  - Required: the first frame is held with `frame_seq=1`, `overflow_cnt=2`. Raising ready gives exactly one handshake.
- Timeout:
  - Stimulus: withhold `drp_drdy` for ch 0x15.
  - Required: `timeout_cnt=1` after 63 cycles, the sequence is discarded, and the next eoc is serviced normally.
- Averaging, macro on, AVG_LOG2=2:
  - Stimulus: four sequences with slot-0 codes 100, 101, 102, 104.
  - Required: a single frame with slot 0 = 101 (407>>2), `frame_seq=4`.
- Reset mid-read:
  - Stimulus: assert reset in WAIT.
  - Required: all outputs are at reset values the next cycle, and a full sequence afterward yields `frame_seq=1`.

Source files
------------

// File: rtl/xadc_frame_capture_if.sv
// DRP read port and frame stream of xadc_frame_capture.
// master = capture engine, slave = XADC DRP / frame consumer side.
interface xadc_frame_capture_if #(
  parameter int NUM_CH = 2,
  parameter int CODE_W = 12
);
  logic                     drp_den;
  logic                     drp_dwe;
  logic [6:0]               drp_daddr;
  logic [15:0]              drp_do;
  logic                     drp_drdy;
  logic                     frame_valid;
  logic                     frame_ready;
  logic [NUM_CH*CODE_W-1:0] frame_data;
  logic [7:0]               frame_seq;

  modport master (
    output drp_den, drp_dwe, drp_daddr, frame_valid, frame_data, frame_seq,
    input  drp_do, drp_drdy, frame_ready
  );

  modport slave (
    input  drp_den, drp_dwe, drp_daddr, frame_valid, frame_data, frame_seq,
    output drp_do, drp_drdy, frame_ready
  );
endinterface

// File: rtl/xadc_frame_capture.sv
// XADC sequence capture: one DRP read per EOC, one NUM_CH-slot frame per complete sequence.
// Define XADC_FRAME_AVG_EN to box-car average 2**AVG_LOG2 complete sequences per frame.
module xadc_frame_capture #(
  parameter int         NUM_CH      = 2,
  parameter logic [4:0] BASE_CH     = 5'h14,
  parameter int         CODE_W      = 12,
  parameter int         AVG_LOG2    = 2,
  parameter int         RDY_TIMEOUT = 63
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 eoc_in,
  input  logic                 eos_in,
  input  logic [4:0]           channel_in,
  xadc_frame_capture_if.master bus,
  output logic [15:0]          overflow_cnt,
  output logic [7:0]           timeout_cnt
);
  localparam int SLOT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TO_W    = $clog2(RDY_TIMEOUT + 1);
  localparam int FRAME_W = NUM_CH * CODE_W;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RDY_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  state_t state, state_nx;

  logic [5:0]         ch_off;
  logic               in_range;
  logic               start_rd, rd_done, rd_timeout, commit;
  logic               complete, frame_go, load;
  logic [SLOT_W-1:0]  slot;
  logic [TO_W-1:0]    wait_cnt;
  logic [NUM_CH-1:0]  slot_ok;
  logic               eos_pend;
  logic [7:0]         seq_cnt;
  logic [CODE_W-1:0]  shadow [NUM_CH];
  logic [FRAME_W-1:0] frame_nx;

  assign ch_off   = {1'b0, channel_in} - {1'b0, BASE_CH};
  assign in_range = ({1'b0, channel_in} >= {1'b0, BASE_CH}) && (ch_off < 6'(NUM_CH));
  assign complete = &slot_ok;
  assign bus.drp_dwe = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_rd) state_nx = S_WAIT;
      S_WAIT:  if (rd_done || rd_timeout) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // A read starting this cycle defers a pending commit so the final EOC's code lands first.
  always_comb begin
    start_rd   = 1'b0;
    rd_done    = 1'b0;
    rd_timeout = 1'b0;
    commit     = 1'b0;
    case (state)
      S_IDLE: begin
        start_rd = eoc_in && in_range;
        commit   = eos_pend && !start_rd;
      end
      S_WAIT: begin
        rd_done    = bus.drp_drdy;
        rd_timeout = !bus.drp_drdy && (wait_cnt == TO_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.drp_den   <= 1'b0;
      bus.drp_daddr <= '0;
      slot          <= '0;
      wait_cnt      <= '0;
      slot_ok       <= '0;
      eos_pend      <= 1'b0;
      seq_cnt       <= '0;
      timeout_cnt   <= '0;
    end else begin
      bus.drp_den <= start_rd;
      if (start_rd) begin
        bus.drp_daddr <= {2'b00, channel_in};
        slot          <= ch_off[SLOT_W-1:0];
      end
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
      if (rd_timeout && timeout_cnt != 8'hFF)
        timeout_cnt <= timeout_cnt + 8'd1;
      eos_pend <= eos_in || (eos_pend && !commit);
      if (commit) begin
        seq_cnt <= seq_cnt + 8'd1;
        slot_ok <= '0;
      end else if (rd_done) begin
        slot_ok[slot] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rd_done)
      shadow[slot] <= bus.drp_do[15 -: CODE_W];
  end

`ifdef XADC_FRAME_AVG_EN
  localparam int ACC_W = CODE_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] AVG_LAST = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]  acc     [NUM_CH];
  logic [ACC_W-1:0]  acc_sum [NUM_CH];
  logic [AVG_LOG2:0] avg_cnt;

  always_comb begin
    frame_nx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      acc_sum[i] = acc[i] + ACC_W'(shadow[i]);
      frame_nx[i*CODE_W +: CODE_W] = acc_sum[i][AVG_LOG2 +: CODE_W];
    end
  end

  assign frame_go = commit && complete && (avg_cnt == AVG_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      avg_cnt <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= '0;
    end else if (commit && complete) begin
      if (avg_cnt == AVG_LAST) begin
        avg_cnt <= '0;
        for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= '0;
      end else begin
        avg_cnt <= avg_cnt + 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= acc_sum[i];
      end
    end
  end
`else
  always_comb begin
    frame_nx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      frame_nx[i*CODE_W +: CODE_W] = shadow[i];
  end

  assign frame_go = commit && complete;
`endif

  assign load = frame_go && (!bus.frame_valid || bus.frame_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.frame_valid <= 1'b0;
      bus.frame_data  <= '0;
      bus.frame_seq   <= '0;
      overflow_cnt    <= '0;
    end else begin
      if (load) begin
        bus.frame_valid <= 1'b1;
        bus.frame_data  <= frame_nx;
        bus.frame_seq   <= seq_cnt + 8'd1;
      end else if (bus.frame_ready) begin
        bus.frame_valid <= 1'b0;
      end
      if (frame_go && !load && overflow_cnt != 16'hFFFF)
        overflow_cnt <= overflow_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_xadc_frame_capture.sv
// Bench for xadc_frame_capture: vector tables, directed corner sequences and a
// randomized run checked against a per-sequence transaction model.
module tb_xadc_frame_capture;
  localparam int         NUM_CH      = 2;
  localparam int         CODE_W      = 12;
  localparam logic [4:0] BASE_CH     = 5'h14;
  localparam int         AVG_LOG2    = 2;
  localparam int         RDY_TIMEOUT = 63;

  logic        clk = 1'b0;
  logic        reset, eoc_in, eos_in;
  logic [4:0]  channel_in;
  logic [15:0] overflow_cnt;
  logic [7:0]  timeout_cnt;

  xadc_frame_capture_if #(.NUM_CH(NUM_CH), .CODE_W(CODE_W)) bus ();

  xadc_frame_capture #(
    .NUM_CH(NUM_CH), .BASE_CH(BASE_CH), .CODE_W(CODE_W),
    .AVG_LOG2(AVG_LOG2), .RDY_TIMEOUT(RDY_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .eoc_in(eoc_in), .eos_in(eos_in),
    .channel_in(channel_in), .bus(bus),
    .overflow_cnt(overflow_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] seq; logic [23:0] data; } frame_t;

  int     n_chk  = 0;
  int     n_fail = 0;
  frame_t got[$];
  logic        hold = 1'b0;
  logic [23:0] hold_data;
  logic [7:0]  hold_seq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Collects handshakes and checks the presented frame is held under back-pressure.
  always @(negedge clk) begin
    if (reset) hold = 1'b0;
    else begin
      if (hold) begin
        chk("hold_valid", bus.frame_valid, 1);
        chk("hold_data", bus.frame_data, hold_data);
        chk("hold_seq", bus.frame_seq, hold_seq);
      end
      if (bus.frame_valid && bus.frame_ready) got.push_back({bus.frame_seq, bus.frame_data});
      hold      = bus.frame_valid && !bus.frame_ready;
      hold_data = bus.frame_data;
      hold_seq  = bus.frame_seq;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rng(input logic [4:0] ch);
    return int'(ch) >= int'(BASE_CH) && int'(ch) < int'(BASE_CH) + NUM_CH;
  endfunction

  task automatic do_reset();
    reset = 1'b1; eoc_in = 1'b0; eos_in = 1'b0;
    bus.drp_drdy = 1'b0; bus.frame_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    got.delete();
  endtask

  task automatic chk_reset_vals();
    chk("rst_den", bus.drp_den, 0);
    chk("rst_dwe", bus.drp_dwe, 0);
    chk("rst_daddr", bus.drp_daddr, 0);
    chk("rst_valid", bus.frame_valid, 0);
    chk("rst_data", bus.frame_data, 0);
    chk("rst_seq", bus.frame_seq, 0);
    chk("rst_overflow", overflow_cnt, 0);
    chk("rst_timeout", timeout_cnt, 0);
  endtask

  // One EOC; if a read is expected, answer after lat cycles (or not at all when !give).
  task automatic rd(input logic [4:0] ch, input logic [15:0] d, input int lat,
                    input bit eos, input bit give, input bit exp_issue);
    eoc_in = 1'b1; channel_in = ch; eos_in = eos;
    step();
    eoc_in = 1'b0; eos_in = 1'b0;
    chk("den", bus.drp_den, exp_issue);
    if (exp_issue) begin
      chk("daddr", bus.drp_daddr, {2'b00, ch});
      repeat (lat) step();
      if (give) begin
        bus.drp_drdy = 1'b1; bus.drp_do = d;
        step();
        bus.drp_drdy = 1'b0; bus.drp_do = 16'($urandom);
      end
    end
    step();
    chk("den_pulse", bus.drp_den, 0);
  endtask

  task automatic send_eos();
    eos_in = 1'b1;
    step();
    eos_in = 1'b0;
    step();
  endtask

  task automatic full_seq(input logic [15:0] d0, input logic [15:0] d1);
    rd(BASE_CH, d0, 0, 1'b0, 1'b1, 1'b1);
    rd(BASE_CH + 5'd1, d1, 0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic wait_frame(input int n);
    int k = 0;
    while (got.size() < n && k < 20) begin step(); k++; end
    chk("frame_arrived", got.size() >= n, 1);
  endtask

  typedef struct { logic [4:0] ch; bit issue; } chv_t;

  task automatic test_channels();
    chv_t chv[7];
    chv[0] = '{5'h13, 1'b0}; chv[1] = '{5'h14, 1'b1}; chv[2] = '{5'h15, 1'b1};
    chv[3] = '{5'h16, 1'b0}; chv[4] = '{5'h10, 1'b0}; chv[5] = '{5'h1F, 1'b0};
    chv[6] = '{5'h00, 1'b0};
    do_reset();
    for (int i = 0; i < 7; i++) rd(chv[i].ch, 16'h1000, i % 3, 1'b0, 1'b1, chv[i].issue);
  endtask

`ifdef XADC_FRAME_AVG_EN
  task automatic test_avg();
    int a0[4] = '{100, 101, 102, 104};
    int a1[4] = '{200, 200, 200, 201};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      full_seq(16'(a0[i] << 4), 16'((a1[i] << 4) | 3));
      if (i < 3) begin
        repeat (4) step();
        chk("avg_no_early_frame", got.size(), 0);
      end
    end
    wait_frame(1);
    chk("avg_slot0", got[0].data[11:0], 101);
    chk("avg_slot1", got[0].data[23:12], 200);
    chk("avg_seq", got[0].seq, 4);
  endtask
`else
  typedef struct { logic [15:0] d0, d1; logic [23:0] exp; } fv_t;

  task automatic test_table();
    fv_t fv[4];
    fv[0] = '{16'hABC0, 16'h1230, 24'h123ABC};
    fv[1] = '{16'hFFFF, 16'h000F, 24'h000FFF};
    fv[2] = '{16'h0000, 16'hFFF0, 24'hFFF000};
    fv[3] = '{16'h5A5A, 16'hA5A5, 24'hA5A5A5};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      full_seq(fv[i].d0, fv[i].d1);
      wait_frame(i + 1);
      chk("tbl_data", got[i].data, fv[i].exp);
      chk("tbl_seq", got[i].seq, i + 1);
    end
    repeat (3) step();
    chk("tbl_one_frame_each", got.size(), 4);
  endtask

  task automatic test_incomplete();
    do_reset();
    rd(5'h10, 16'h1110, 0, 1'b0, 1'b1, 1'b0);
    rd(BASE_CH, 16'h2220, 0, 1'b0, 1'b1, 1'b1);
    send_eos();
    repeat (5) step();
    chk("inc_no_frame", got.size(), 0);
    chk("inc_valid", bus.frame_valid, 0);
    full_seq(16'h3330, 16'h4440);
    wait_frame(1);
    chk("inc_next_seq", got[0].seq, 2);
    chk("inc_next_data", got[0].data, 24'h444333);
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.frame_ready = 1'b0;
    full_seq(16'h0110, 16'h0220);
    full_seq(16'h0330, 16'h0440);
    full_seq(16'h0550, 16'h0660);
    repeat (3) step();
    chk("bp_valid", bus.frame_valid, 1);
    chk("bp_seq", bus.frame_seq, 1);
    chk("bp_data", bus.frame_data, 24'h022011);
    chk("bp_overflow", overflow_cnt, 2);
    chk("bp_no_handshake", got.size(), 0);
    bus.frame_ready = 1'b1;
    repeat (5) step();
    chk("bp_one_handshake", got.size(), 1);
    chk("bp_hs_seq", got[0].seq, 1);
    chk("bp_valid_drop", bus.frame_valid, 0);
  endtask

  task automatic test_timeout();
    do_reset();
    rd(BASE_CH, 16'h7770, 0, 1'b0, 1'b1, 1'b1);
    eoc_in = 1'b1; channel_in = BASE_CH + 5'd1;
    step();
    eoc_in = 1'b0;
    chk("to_den", bus.drp_den, 1);
    repeat (RDY_TIMEOUT - 1) step();
    chk("to_before", timeout_cnt, 0);
    step();
    chk("to_after", timeout_cnt, 1);
    send_eos();
    repeat (4) step();
    chk("to_no_frame", got.size(), 0);
    full_seq(16'h8880, 16'h9990);
    wait_frame(1);
    chk("to_next_seq", got[0].seq, 2);
    chk("to_next_data", got[0].data, 24'h999888);
    chk("to_count_kept", timeout_cnt, 1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    eoc_in = 1'b1; channel_in = BASE_CH + 5'd1;
    step();
    eoc_in = 1'b0;
    chk("rm_den", bus.drp_den, 1);
    repeat (3) step();
    reset = 1'b1;
    step();
    chk_reset_vals();
    reset = 1'b0;
    repeat (RDY_TIMEOUT + 5) step();
    chk("rm_no_timeout", timeout_cnt, 0);
    got.delete();
    full_seq(16'h4440, 16'h5550);
    wait_frame(1);
    chk("rm_seq", got[0].seq, 1);
    chk("rm_data", got[0].data, 24'h555444);
  endtask
`endif

  // Transaction-level model: one entry per EOS, frame when every slot was read in it.
  task automatic test_random();
    frame_t      exp_q[$];
    logic [7:0]  m_seq;
    int          m_to, nev, kind, sl, mode;
    bit          ok[NUM_CH];
    logic [11:0] code[NUM_CH];
    logic [15:0] d;
    logic [4:0]  ch;
    logic [23:0] fd;
    bit          all_ok;
    int          acc[NUM_CH];
    int          acnt;
    do_reset();
    m_seq = 8'd0; m_to = 0; acnt = 0;
    for (int i = 0; i < NUM_CH; i++) acc[i] = 0;
    for (int s = 0; s < 300; s++) begin
      for (int i = 0; i < NUM_CH; i++) ok[i] = 1'b0;
      nev = $urandom_range(0, 3);
      for (int e = 0; e < nev; e++) begin
        kind = $urandom_range(0, 9);
        sl   = $urandom_range(0, NUM_CH - 1);
        d    = 16'($urandom);
        if (kind == 0) begin
          ch = 5'($urandom_range(0, 31));
          if (in_rng(ch)) ch = ch ^ 5'h08;
          rd(ch, d, 0, 1'b0, 1'b1, 1'b0);
        end else if (kind == 1 && m_to < 4) begin
          rd(BASE_CH + 5'(sl), d, 0, 1'b0, 1'b0, 1'b1);
          repeat (RDY_TIMEOUT - 1) step();
          m_to++;
        end else begin
          rd(BASE_CH + 5'(sl), d, $urandom_range(0, 4), 1'b0, 1'b1, 1'b1);
          ok[sl] = 1'b1; code[sl] = d[15:4];
        end
      end
      mode = $urandom_range(0, 9);
      if (mode == 0) send_eos();
      else if (mode == 1) begin
        sl = $urandom_range(0, NUM_CH - 1); d = 16'($urandom);
        rd(BASE_CH + 5'(sl), d, $urandom_range(0, 3), 1'b1, 1'b1, 1'b1);
        ok[sl] = 1'b1; code[sl] = d[15:4];
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          d = 16'($urandom);
          rd(BASE_CH + 5'(i), d, $urandom_range(0, 3), (i == NUM_CH - 1) && (mode > 3), 1'b1, 1'b1);
          ok[i] = 1'b1; code[i] = d[15:4];
        end
        if (mode <= 3) send_eos();
      end
      m_seq = m_seq + 8'd1;
      all_ok = 1'b1;
      for (int i = 0; i < NUM_CH; i++) all_ok = all_ok && ok[i];
      if (all_ok) begin
`ifdef XADC_FRAME_AVG_EN
        for (int i = 0; i < NUM_CH; i++) acc[i] = acc[i] + int'(code[i]);
        acnt++;
        if (acnt == (1 << AVG_LOG2)) begin
          for (int i = 0; i < NUM_CH; i++) begin
            fd[i*12 +: 12] = 12'(acc[i] >> AVG_LOG2);
            acc[i] = 0;
          end
          acnt = 0;
          exp_q.push_back({m_seq, fd});
        end
`else
        for (int i = 0; i < NUM_CH; i++) fd[i*12 +: 12] = code[i];
        exp_q.push_back({m_seq, fd});
`endif
      end
    end
    repeat (10) step();
    chk("rand_frame_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got.size()) begin
        chk("rand_seq", got[i].seq, exp_q[i].seq);
        chk("rand_data", got[i].data, exp_q[i].data);
      end
    end
    chk("rand_timeout_cnt", timeout_cnt, m_to);
    chk("rand_overflow_cnt", overflow_cnt, 0);
  endtask

  initial begin
    reset = 1'b1; eoc_in = 1'b0; eos_in = 1'b0; channel_in = '0;
    bus.drp_do = '0; bus.drp_drdy = 1'b0; bus.frame_ready = 1'b1;
    step(); step();
    chk_reset_vals();
    reset = 1'b0;
    test_channels();
`ifdef XADC_FRAME_AVG_EN
    test_avg();
`else
    test_table();
    test_incomplete();
    test_backpressure();
    test_timeout();
    test_reset_mid();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
